bcd_display_driver: RTL and testbench

Sequential binary-to-BCD converter and seven-segment driver that sits directly downstream of the ALU. It accepts the ALU's 8-bit unsigned result over a valid/ready handshake and converts it with an 8-step shift-and-add-3 (double-dabble) sequence. It then latches three BCD digits and drives three seven-segment displays. The display holds the last converted value until the next conversion completes.

---
 rtl/bcd_display_driver_pkg.sv | 56 +++++
 rtl/bcd_display_driver_seg7_decoder.sv | 29 ++
 rtl/bcd_display_driver.sv | 136 +++++++++++++
 tb/tb_bcd_display_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_driver_pkg.sv
// Shared constants for the BCD display driver: state encodings, the active-high
// seven-segment patterns and the double-dabble nibble adjust.
package bcd_display_driver_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Segment order {g,f,e,d,c,b,a}; a set bit means the segment is lit.
    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_DIGIT_0;
            4'd1:    pat = SEG_DIGIT_1;
            4'd2:    pat = SEG_DIGIT_2;
            4'd3:    pat = SEG_DIGIT_3;
            4'd4:    pat = SEG_DIGIT_4;
            4'd5:    pat = SEG_DIGIT_5;
            4'd6:    pat = SEG_DIGIT_6;
            4'd7:    pat = SEG_DIGIT_7;
            4'd8:    pat = SEG_DIGIT_8;
            4'd9:    pat = SEG_DIGIT_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
        logic [3:0] res;
        if (nibble >= 4'd5) begin
            res = nibble + 4'd3;
        end else begin
            res = nibble;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_display_driver_seg7_decoder.sv
// Combinational seven-segment decoder with blanking and selectable polarity;
// the parent registers its output.
module seg7_decoder
    import bcd_display_driver_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] lit_s;

    // Select lit pattern, then apply board polarity.
    always_comb begin
        if (blank_i) begin
            lit_s = SEG_BLANK;
        end else begin
            lit_s = seg_pattern(digit_i);
        end
        if (ACTIVE_LOW_SEG) begin
            seg_o = ~lit_s;
        end else begin
            seg_o = lit_s;
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one step per
// cycle) with registered seven-segment outputs and leading-zero blanking.
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_value,
    output logic        in_ready,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam logic [6:0] SEG_ZERO_OUT  = ACTIVE_LOW_SEG ? ~SEG_DIGIT_0 : SEG_DIGIT_0;
    localparam logic [6:0] SEG_BLANK_OUT = ACTIVE_LOW_SEG ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [6:0] LEAD_RST      = BLANK_LEADING ? SEG_BLANK_OUT : SEG_ZERO_OUT;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    bcd_t        scratch_q, scratch_d;
    logic [11:0] bcd_q, bcd_d;
    logic [6:0]  hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
    logic        done_q, done_d;

    bcd_t        adj_s;
    bcd_t        final_s;
    logic [19:0] shift_s;
    logic        blank2_s, blank1_s;
    logic [6:0]  seg2_s, seg1_s, seg0_s;

    // One double-dabble step on the current scratch/binary pair.
    always_comb begin
        adj_s.hundreds = add3_if_ge5(scratch_q.hundreds);
        adj_s.tens     = add3_if_ge5(scratch_q.tens);
        adj_s.ones     = add3_if_ge5(scratch_q.ones);
        shift_s        = {adj_s, bin_q} << 1;
        final_s        = shift_s[19:8];
        blank2_s       = BLANK_LEADING && (final_s.hundreds == 4'd0);
        blank1_s       = BLANK_LEADING && (final_s.hundreds == 4'd0) && (final_s.tens == 4'd0);
    end

    seg7_decoder #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec2 (
        .digit_i(final_s.hundreds), .blank_i(blank2_s), .seg_o(seg2_s)
    );
    seg7_decoder #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec1 (
        .digit_i(final_s.tens), .blank_i(blank1_s), .seg_o(seg1_s)
    );
    seg7_decoder #(.ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)) u_dec0 (
        .digit_i(final_s.ones), .blank_i(1'b0), .seg_o(seg0_s)
    );

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Next-state: accept in IDLE/DONE, step in SHIFT, publish on the last step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        hex2_d    = hex2_q;
        hex1_d    = hex1_q;
        hex0_d    = hex0_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_valid && in_ready) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = 3'd0;
                    bin_d     = in_value;
                    scratch_d = 12'h000;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scratch_d = final_s;
                bin_d     = shift_s[7:0];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bcd_d   = final_s;
                    hex2_d  = seg2_s;
                    hex1_d  = seg1_s;
                    hex0_d  = seg0_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any conversion in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            bin_q     <= 8'h00;
            scratch_q <= 12'h000;
            bcd_q     <= 12'h000;
            hex2_q    <= LEAD_RST;
            hex1_q    <= LEAD_RST;
            hex0_q    <= SEG_ZERO_OUT;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            hex2_q    <= hex2_d;
            hex1_q    <= hex1_d;
            hex0_q    <= hex0_d;
            done_q    <= done_d;
        end
    end

    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign hex2    = hex2_q;
    assign hex1    = hex1_q;
    assign hex0    = hex0_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: four parameter variants share one stimulus stream
// and are checked every cycle against a decimal-arithmetic model.
module tb_bcd_display_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_value = 8'h00;

    logic        in_ready_w [4];
    logic        done_w     [4];
    logic [11:0] bcd_w      [4];
    logic [6:0]  hex2_w     [4];
    logic [6:0]  hex1_w     [4];
    logic [6:0]  hex0_w     [4];

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    // Variant i: active-low when i is even, leading blanking when i < 2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        bcd_display_driver #(
            .ACTIVE_LOW_SEG((g % 2) == 0),
            .BLANK_LEADING (g < 2)
        ) u_dut (
            .clock   (clock),
            .reset   (reset),
            .in_valid(in_valid),
            .in_value(in_value),
            .in_ready(in_ready_w[g]),
            .done    (done_w[g]),
            .bcd_out (bcd_w[g]),
            .hex2    (hex2_w[g]),
            .hex1    (hex1_w[g]),
            .hex0    (hex0_w[g])
        );
    end

    localparam logic [6:0] LOW_PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input int idx, input logic [11:0] act,
                       input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d, input bit blank, input bit al);
        logic [6:0] lo;
        if (blank || d > 4'd9) lo = 7'h7F;
        else                   lo = LOW_PAT[d];
        return al ? lo : ~lo;
    endfunction

    // Model: a conversion occupies 8 cycles after acceptance, then shows the decimal digits.
    int         m_rem  = 0;
    logic [7:0] m_val  = 8'h00;
    logic       m_done = 1'b0;
    logic [11:0] m_bcd = 12'h000;

    always @(posedge clock) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_bcd  <= 12'h000;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_bcd  <= to_bcd(int'(m_val));
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (in_valid) begin
                m_val <= in_value;
                m_rem <= 8;
            end
        end
    end

    // Every-cycle comparison of all variants against the model.
    always @(negedge clock) begin
        if (check_en) begin
            for (int i = 0; i < 4; i++) begin
                bit al, bl;
                al = (i % 2) == 0;
                bl = i < 2;
                chk("in_ready", i, 12'(in_ready_w[i]), 12'(m_rem == 0));
                chk("done", i, 12'(done_w[i]), 12'(m_done));
                chk("bcd_out", i, bcd_w[i], m_bcd);
                chk("hex2", i, 12'(hex2_w[i]),
                    12'(exp_seg(m_bcd[11:8], bl && m_bcd[11:8] == 4'd0, al)));
                chk("hex1", i, 12'(hex1_w[i]),
                    12'(exp_seg(m_bcd[7:4], bl && m_bcd[11:4] == 8'h00, al)));
                chk("hex0", i, 12'(hex0_w[i]), 12'(exp_seg(m_bcd[3:0], 1'b0, al)));
            end
        end
    end

    task automatic convert(input logic [7:0] v, output int cycles);
        @(negedge clock);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clock);
        in_valid = 1'b0;
        in_value = 8'($urandom);
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clock);
            cycles++;
            if (done_w[0]) break;
        end
    endtask

    int cyc, gap, busy_seen, done_seen;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_en = 1'b1;
        chk("rst_bcd", 0, bcd_w[0], 12'h000);
        chk("rst_hex0", 0, 12'(hex0_w[0]), 12'h040);
        chk("rst_hex2", 0, 12'(hex2_w[0]), 12'h07F);
        chk("rst_hex1_ah", 1, 12'(hex1_w[1]), 12'h000);
        chk("rst_hex2_nb", 2, 12'(hex2_w[2]), 12'h040);
        chk("rst_ready", 0, 12'(in_ready_w[0]), 12'h001);

        convert(8'd0, cyc);
        chk("lat_zero", 0, 12'(cyc), 12'd8);
        chk("zero_bcd", 0, bcd_w[0], 12'h000);
        chk("zero_hex0", 0, 12'(hex0_w[0]), 12'h040);
        chk("zero_hex1", 0, 12'(hex1_w[0]), 12'h07F);
        chk("zero_hex2", 0, 12'(hex2_w[0]), 12'h07F);

        convert(8'd255, cyc);
        chk("lat_max", 0, 12'(cyc), 12'd8);
        chk("max_bcd", 0, bcd_w[0], 12'h255);
        chk("max_hex2", 0, 12'(hex2_w[0]), 12'h024);
        chk("max_hex1", 0, 12'(hex1_w[0]), 12'h012);
        chk("max_hex0", 0, 12'(hex0_w[0]), 12'h012);
        @(negedge clock);
        chk("max_done_width", 0, 12'(done_w[0]), 12'h000);

        convert(8'd47, cyc);
        chk("b47_bcd", 0, bcd_w[0], 12'h047);
        chk("b47_hex2", 0, 12'(hex2_w[0]), 12'h07F);
        chk("b47_hex1", 0, 12'(hex1_w[0]), 12'h019);
        chk("b47_hex0", 0, 12'(hex0_w[0]), 12'h078);
        chk("b47_hex2_nb", 2, 12'(hex2_w[2]), 12'h040);
        chk("b47_hex2_ah", 1, 12'(hex2_w[1]), 12'h000);

        // Back-to-back: valid held, value changed while busy.
        @(negedge clock);
        in_valid = 1'b1;
        in_value = 8'd100;
        @(negedge clock);
        in_value = 8'd200;
        busy_seen = 0;
        if (in_ready_w[0]) busy_seen++;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (done_w[0]) break;
            if (in_ready_w[0]) busy_seen++;
        end
        chk("b2b_lat", 0, 12'(cyc), 12'd8);
        chk("b2b_first", 0, bcd_w[0], 12'h100);
        @(negedge clock);
        in_valid = 1'b0;
        gap = 1;
        while (gap < 20) begin
            @(negedge clock);
            gap++;
            if (done_w[0]) break;
            if (in_ready_w[0]) busy_seen++;
        end
        chk("b2b_gap", 0, 12'(gap), 12'd9);
        chk("b2b_second", 0, bcd_w[0], 12'h200);
        chk("b2b_busy_ready", 0, 12'(busy_seen), 12'd0);

        // Reset lands on the 4th shift edge of 123.
        @(negedge clock);
        in_valid = 1'b1;
        in_value = 8'd123;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_bcd", 0, bcd_w[0], 12'h000);
        chk("abort_ready", 0, 12'(in_ready_w[0]), 12'h001);
        done_seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done_w[0]) done_seen++;
        end
        chk("abort_no_done", 0, 12'(done_seen), 12'd0);

        for (int v = 0; v < 256; v++) begin
            convert(8'(v), cyc);
            chk("sweep_lat", v, 12'(cyc), 12'd8);
        end

        @(negedge clock);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
